// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the sequential multiply/divide unit.
//   - mdu_op_e    : E-stage MDU operation encodings (13-15 decode as NONE)
//   - mdu_state_e : sequencer state encoding
//   - DEF_MULT_CYCLES / DEF_DIV_CYCLES : default busy latencies
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational arithmetic for the MDU.
// Computes the HI/LO value an op would produce from the current operands
// and the current HI/LO (needed by the accumulate forms).
// Ports:
//   op           : operation code (mdu_op_e encoding)
//   a, b         : rs / rt operands
//   hi, lo       : current HI/LO contents
//   we           : 1 when the op produces a result to commit
//   res_hi/res_lo: result to commit (equal to hi/lo when we=0)
// Optional feature: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic        we,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic [63:0] a_sx;
   logic [63:0] b_sx;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        is_sdiv;
   logic [31:0] dvd;
   logic [31:0] dvs;
   logic [31:0] uq;
   logic [31:0] ur;

   // Low 64 bits of the product of sign-extended operands equal the
   // signed 32x32 product, so one unsigned multiplier form serves both.
   assign a_sx   = {{32{a[31]}}, a};
   assign b_sx   = {{32{b[31]}}, b};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide runs on magnitudes through one unsigned divider; the
   // signs are restored afterwards. This also yields 0x80000000 / -1 =
   // 0x80000000 rem 0 with no special case. A zero divisor is replaced by 1
   // only to keep the divider defined; that result is never committed.
   assign is_sdiv = (op == OP_DIV);
   assign dvd     = (is_sdiv && a[31]) ? -a : a;
   assign dvs     = (b == 32'd0) ? 32'd1 : ((is_sdiv && b[31]) ? -b : b);
   assign uq      = dvd / dvs;
   assign ur      = dvd % dvs;

   always_comb begin
      we     = 1'b0;
      res_hi = hi;
      res_lo = lo;
      case (op)
         OP_MULT: begin
            we               = 1'b1;
            {res_hi, res_lo} = prod_s;
         end
         OP_MULTU: begin
            we               = 1'b1;
            {res_hi, res_lo} = prod_u;
         end
         OP_DIV: begin
            we     = (b != 32'd0);
            res_lo = (a[31] ^ b[31]) ? -uq : uq;
            res_hi = a[31] ? -ur : ur;
         end
         OP_DIVU: begin
            we     = (b != 32'd0);
            res_lo = uq;
            res_hi = ur;
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            we               = 1'b1;
            {res_hi, res_lo} = {hi, lo} + prod_s;
         end
         OP_MADDU: begin
            we               = 1'b1;
            {res_hi, res_lo} = {hi, lo} + prod_u;
         end
         OP_MSUB: begin
            we               = 1'b1;
            {res_hi, res_lo} = {hi, lo} - prod_s;
         end
         OP_MSUBU: begin
            we               = 1'b1;
            {res_hi, res_lo} = {hi, lo} - prod_u;
         end
`endif
         default: begin
            we = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit with HI/LO registers.
// A mult/div-class op is issued in one cycle (start), the result is
// computed by mdu_calc and held in shadow registers, busy is held for
// MULT_CYCLES or DIV_CYCLES cycles, and the shadow is committed to HI/LO
// on the edge that ends the last busy cycle.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req        : exception/interrupt flush; suppresses issue and MTHI/MTLO
//   op, a, b   : E-stage operation and forwarded operands
//   start      : combinational, op issued this cycle
//   busy       : registered, op in flight
//   rdata      : combinational MFHI/MFLO read data, else 0
//   state_dbg  : current sequencer state
// Handshake: start is a one-cycle issue pulse; the pipeline must not
// present a new mult/div op while busy=1 (such ops are ignored).
// Optional feature: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        start,
   output logic        busy,
   output logic [31:0] rdata,
   output mdu_state_e  state_dbg
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   mdu_state_e       state;
   mdu_state_e       state_nx;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      hi;
   logic [31:0]      lo;
   logic [31:0]      sh_hi;
   logic [31:0]      sh_lo;
   logic             sh_we;
   logic             calc_we;
   logic [31:0]      calc_hi;
   logic [31:0]      calc_lo;
   logic             is_mul;
   logic             is_div;
   logic             issue_ok;
   logic             last;

   always_comb begin
      is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
      is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
`endif
   end

   assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
   assign issue_ok = (state == ST_IDLE) && !req;
   assign start    = issue_ok && (is_mul || is_div);
   assign last     = (state != ST_IDLE) && (cnt == CNT_W'(1));

   mdu_calc u_calc (
      .op     (op),
      .a      (a),
      .b      (b),
      .hi     (hi),
      .lo     (lo),
      .we     (calc_we),
      .res_hi (calc_hi),
      .res_lo (calc_lo)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (start) state_nx = is_div ? ST_DIV : ST_MULT;
         end
         ST_MULT, ST_DIV: begin
            if (cnt == CNT_W'(1)) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Counter, busy flag and shadow result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         busy  <= 1'b0;
         sh_hi <= '0;
         sh_lo <= '0;
         sh_we <= 1'b0;
      end else if (start) begin
         cnt   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         busy  <= 1'b1;
         sh_hi <= calc_hi;
         sh_lo <= calc_lo;
         sh_we <= calc_we;
      end else if (state != ST_IDLE) begin
         cnt <= cnt - 1'b1;
         if (last) busy <= 1'b0;
      end
   end

   // HI/LO: commit at the end of the last busy cycle; MTHI/MTLO only when
   // idle and not flushed (the two cases are mutually exclusive).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (last) begin
         if (sh_we) begin
            hi <= sh_hi;
            lo <= sh_lo;
         end
      end else if (issue_ok) begin
         if (op == OP_MTHI) hi <= a;
         if (op == OP_MTLO) lo <= a;
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (op == OP_MFHI)      rdata = hi;
      else if (op == OP_MFLO) rdata = lo;
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq. Inputs are driven on the
// falling edge and outputs sampled 1ns later; a behavioural HI/LO model
// computed with 64-bit integer arithmetic supplies all expected values.
module tb_mdu_seq;
   import mdu_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        start;
   logic        busy;
   logic [31:0] rdata;
   mdu_state_e  state_dbg;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   mdu_seq #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .op        (op),
      .a         (a),
      .b         (b),
      .start     (start),
      .busy      (busy),
      .rdata     (rdata),
      .state_dbg (state_dbg)
   );

   // scoreboard check
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference model: new HI/LO after op, from architectural rules
   task automatic ref_exec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           inout logic [31:0] h, inout logic [31:0] l);
      longint          sx, sy, q, r;
      longint unsigned ux, uy, acc;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      ux  = {32'd0, x};
      uy  = {32'd0, y};
      acc = {h, l};
      case (o)
         4'd1: {h, l} = sx * sy;
         4'd2: {h, l} = ux * uy;
         4'd3: if (y != 0) begin
            q = sx / sy;
            r = sx % sy;
            l = q[31:0];
            h = r[31:0];
         end
         4'd4: if (y != 0) begin
            acc = ux / uy;
            l   = acc[31:0];
            acc = ux % uy;
            h   = acc[31:0];
         end
         4'd7: h = x;
         4'd8: l = x;
`ifdef MDU_MADD_EN
         4'd9:  {h, l} = acc + longint'(sx * sy);
         4'd10: {h, l} = acc + ux * uy;
         4'd11: {h, l} = acc - longint'(sx * sy);
         4'd12: {h, l} = acc - ux * uy;
`endif
         default: ;
      endcase
   endtask

   function automatic int cycles_for(input logic [3:0] o);
      if (o == 4'd1 || o == 4'd2) return MC;
      if (o == 4'd3 || o == 4'd4) return DC;
`ifdef MDU_MADD_EN
      if (o >= 4'd9 && o <= 4'd12) return MC;
`endif
      return 0;
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // driver: apply inputs on the falling edge, settle 1ns
   task automatic step(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic rq);
      @(negedge clk);
      op  = o;
      a   = x;
      b   = y;
      req = rq;
      #1;
   endtask

   task automatic read_back(input string tag);
      step(OP_MFHI, $urandom, $urandom, 1'($urandom_range(0, 1)));
      check({tag, "_busy_done"}, busy, 0);
      check({tag, "_hi"}, rdata, hi_m);
      step(OP_MFLO, $urandom, $urandom, 1'b0);
      check({tag, "_lo"}, rdata, lo_m);
   endtask

   task automatic read_const(input string tag, input logic [31:0] eh, input logic [31:0] el);
      step(OP_MFHI, 32'd0, 32'd0, 1'b0);
      check({tag, "_hi_const"}, rdata, eh);
      step(OP_MFLO, 32'd0, 32'd0, 1'b0);
      check({tag, "_lo_const"}, rdata, el);
   endtask

   // issue one op, run its busy window with ignored traffic, verify commit
   task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit req_pulse);
      logic [31:0] nh, nl;
      logic [3:0]  so;
      int          n;
      nh = hi_m;
      nl = lo_m;
      n  = cycles_for(o);
      ref_exec(o, x, y, nh, nl);
      step(o, x, y, 1'b0);
      check({tag, "_start"}, start, 64'(n > 0));
      check({tag, "_busy_issue"}, busy, 0);
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 4))
            0: so = OP_MFHI;
            1: so = OP_MFLO;
            2: so = OP_MTHI;
            3: so = OP_MULT;
            default: so = OP_DIV;
         endcase
         step(so, $urandom, $urandom, req_pulse ? 1'(i % 2 == 0) : 1'($urandom_range(0, 1)));
         check({tag, "_busy"}, busy, 1);
         check({tag, "_start_busy"}, start, 0);
         check({tag, "_rdata_busy"}, rdata,
               (so == OP_MFHI) ? hi_m : ((so == OP_MFLO) ? lo_m : 32'd0));
      end
      hi_m = nh;
      lo_m = nl;
      read_back(tag);
   endtask

   logic [3:0] rop;

   initial begin
      reset = 1'b1;
      req   = 1'b0;
      op    = OP_MULT;
      a     = 32'd0;
      b     = 32'd0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_state", state_dbg, ST_IDLE);
      check("rst_start_decode", start, 1);
      op = OP_MFHI;
      #1;
      check("rst_rdata_hi", rdata, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      read_back("post_rst");

      // signed multiply
      run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      read_const("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      // signed divide, divide by zero, overflow divide
      run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      read_const("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu0", OP_DIVU, 32'd7, 32'd0, 1'b0);
      read_const("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      read_const("divovf", 32'd0, 32'h8000_0000);

      // flush blocks issue and MTHI
      step(OP_MULT, 32'd5, 32'd7, 1'b1);
      check("req_start", start, 0);
      step(OP_NONE, 32'd0, 32'd0, 1'b0);
      check("req_busy", busy, 0);
      step(OP_MTHI, 32'h1234, 32'd0, 1'b1);
      check("req_mthi_start", start, 0);
      read_back("req_block");

      // flush during busy does not cancel
      run_op("multu_req", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1);
      read_const("multu_req", 32'd1, 32'd0);

      // reset in busy cycle 3 of a divide
      run_op("mthi", OP_MTHI, 32'hA5A5_0001, 32'd0, 1'b0);
      run_op("mtlo", OP_MTLO, 32'h5A5A_0002, 32'd0, 1'b0);
      step(OP_DIV, 32'd100, 32'd7, 1'b0);
      check("rstdiv_start", start, 1);
      for (int i = 0; i < 3; i++) begin
         step(OP_NONE, 32'd0, 32'd0, 1'b0);
         check("rstdiv_busy", busy, 1);
      end
      op    = OP_MFHI;
      reset = 1'b1;
      #1;
      check("rstdiv_busy_clr", busy, 0);
      check("rstdiv_hi_clr", rdata, 0);
      check("rstdiv_state", state_dbg, ST_IDLE);
      @(negedge clk);
      reset = 1'b0;
      hi_m  = 32'd0;
      lo_m  = 32'd0;
      for (int i = 0; i < DC + 2; i++) begin
         step(OP_NONE, 32'd0, 32'd0, 1'b0);
         check("rstdiv_no_busy", busy, 0);
      end
      read_back("rstdiv");

`ifdef MDU_MADD_EN
      run_op("mt_hi0", OP_MTHI, 32'd0, 32'd0, 1'b0);
      run_op("mt_lo5", OP_MTLO, 32'd5, 32'd0, 1'b0);
      run_op("madd", OP_MADD, 32'd2, 32'd3, 1'b0);
      read_const("madd", 32'd0, 32'd11);
`else
      step(OP_MADD, 32'd2, 32'd3, 1'b0);
      check("op9_start", start, 0);
      step(OP_NONE, 32'd0, 32'd0, 1'b0);
      check("op9_busy", busy, 0);
      read_back("op9");
`endif

      // randomized traffic
      for (int k = 0; k < 60; k++) begin
`ifdef MDU_MADD_EN
         rop = 4'($urandom_range(1, 12));
`else
         rop = 4'($urandom_range(1, 8));
`endif
         if (rop == OP_MFHI || rop == OP_MFLO) rop = OP_MULTU;
         run_op("rnd", rop, rnd_val(), rnd_val(), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
